// File: rtl/alu_ctrl_dm_if.sv
// Execute/memory slice bus: instruction fields and operands in,
// control word, ALU result and write-back data out.
interface alu_ctrl_dm_if;
    // instruction fields and operands
    logic [6:0]  Op;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] immout;

    // control word
    logic        RegWrite;
    logic        MemWrite;
    logic        ALUSrc;
    logic [5:0]  EXTOp;
    logic [4:0]  ALUOp;
    logic [2:0]  DMType;
    logic [1:0]  WDSel;

    // datapath results
    logic [31:0] aluout;
    logic        Zero;
    logic [31:0] dout;
    logic [31:0] WD;

    // producer of instruction/operands (register file side)
    modport master (
        output Op, Funct7, Funct3, RD1, RD2, immout,
        input  RegWrite, MemWrite, ALUSrc, EXTOp, ALUOp, DMType, WDSel,
        input  aluout, Zero, dout, WD
    );

    // the execute/memory slice itself
    modport slave (
        input  Op, Funct7, Funct3, RD1, RD2, immout,
        output RegWrite, MemWrite, ALUSrc, EXTOp, ALUOp, DMType, WDSel,
        output aluout, Zero, dout, WD
    );
endinterface

// File: rtl/alu_ctrl_dm.sv
// Single-cycle RV32I execute/memory slice: main decoder, 32-bit ALU with
// operand-B select, and a byte-addressed little-endian data memory with
// sized, wrapping loads/stores. The data memory is the only state.
module alu_ctrl_dm #(
    parameter int unsigned DM_BYTES = 128
) (
    input  logic         clk,
    input  logic         rst,
    alu_ctrl_dm_if.slave bus
);

    localparam int unsigned AW = (DM_BYTES > 1) ? $clog2(DM_BYTES) : 1;

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_LUI   = 7'b0110111
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLL  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_OR   = 5'd9,
        ALU_AND  = 5'd10,
        ALU_LUI  = 5'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_H  = 3'b001,
        DM_HU = 3'b010,
        DM_B  = 3'b011,
        DM_BU = 3'b100
    } dm_type_e;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_U     = 6'b000010;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;

    // control word
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic [5:0]  ext_op;
    alu_op_e     alu_op;
    dm_type_e    dm_type;
    logic [1:0]  wd_sel;

    // funct-field decode shared by R-type and I-ALU
    alu_op_e     f_op;
    logic        f_ok;

    // datapath
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;
    logic [31:0] ld_data;
    logic [31:0] wd;

    // data memory
    logic [7:0]    mem [DM_BYTES];
    logic [AW-1:0] addr [4];
    logic [7:0]    rb [4];

    // Funct3/Funct7 to ALU operation; f_ok flags R-type funct7 values that are legal
    always_comb begin
        f_op = ALU_NOP;
        f_ok = 1'b1;
        unique case (bus.Funct3)
            3'b000: f_op = (bus.Op == OP_R && bus.Funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b001: f_op = ALU_SLL;
            3'b010: f_op = ALU_SLT;
            3'b011: f_op = ALU_SLTU;
            3'b100: f_op = ALU_XOR;
            3'b101: f_op = bus.Funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: f_op = ALU_OR;
            3'b111: f_op = ALU_AND;
            default: f_op = ALU_NOP;
        endcase
        if (bus.Op == OP_R) begin
            f_ok = (bus.Funct7 == 7'b0000000) ||
                   (bus.Funct7 == 7'b0100000 &&
                    (bus.Funct3 == 3'b000 || bus.Funct3 == 3'b101));
        end
    end

    // Main decoder: anything not recognised leaves every control output at 0
    always_comb begin
        reg_write = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        ext_op    = '0;
        alu_op    = ALU_NOP;
        dm_type   = DM_W;
        wd_sel    = WD_ALU;
        unique case (bus.Op)
            OP_R: begin
                if (f_ok) begin
                    reg_write = 1'b1;
                    alu_op    = f_op;
                end
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                ext_op    = (bus.Funct3 == 3'b001 || bus.Funct3 == 3'b101) ? EXT_SHAMT : EXT_I;
                alu_op    = f_op;
            end
            OP_LOAD: begin
                if (bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    ext_op    = EXT_I;
                    alu_op    = ALU_ADD;
                    wd_sel    = WD_MEM;
                    unique case (bus.Funct3)
                        3'b000:  dm_type = DM_B;
                        3'b001:  dm_type = DM_H;
                        3'b100:  dm_type = DM_BU;
                        3'b101:  dm_type = DM_HU;
                        default: dm_type = DM_W;
                    endcase
                end
            end
            OP_STORE: begin
                if (bus.Funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    ext_op    = EXT_S;
                    alu_op    = ALU_ADD;
                    unique case (bus.Funct3)
                        3'b000:  dm_type = DM_B;
                        3'b001:  dm_type = DM_H;
                        default: dm_type = DM_W;
                    endcase
                end
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                ext_op    = EXT_U;
                alu_op    = ALU_LUI;
            end
            default: ;
        endcase
    end

    assign alu_a = bus.RD1;
    assign alu_b = alu_src ? bus.immout : bus.RD2;

    // 32-bit ALU, wrap-around arithmetic, shift amount from B[4:0]
    always_comb begin
        alu_c = '0;
        unique case (alu_op)
            ALU_ADD:  alu_c = alu_a + alu_b;
            ALU_SUB:  alu_c = alu_a - alu_b;
            ALU_SLL:  alu_c = alu_a << alu_b[4:0];
            ALU_SLT:  alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_c = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_c = alu_a ^ alu_b;
            ALU_SRL:  alu_c = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:   alu_c = alu_a | alu_b;
            ALU_AND:  alu_c = alu_a & alu_b;
            ALU_LUI:  alu_c = alu_b;
            default:  alu_c = '0;
        endcase
    end

    // Byte lane addresses: the AW-bit adder wraps each lane modulo DM_BYTES
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            addr[i] = alu_c[AW-1:0] + AW'(i);
            rb[i]   = mem[addr[i]];
        end
    end

    // Sized load with sign/zero extension; driven for every DMType
    always_comb begin
        ld_data = '0;
        unique case (dm_type)
            DM_W:  ld_data = {rb[3], rb[2], rb[1], rb[0]};
            DM_H:  ld_data = {{16{rb[1][7]}}, rb[1], rb[0]};
            DM_HU: ld_data = {16'd0, rb[1], rb[0]};
            DM_B:  ld_data = {{24{rb[0][7]}}, rb[0]};
            DM_BU: ld_data = {24'd0, rb[0]};
            default: ld_data = '0;
        endcase
    end

    // Memory update: reset clears every byte and wins over a concurrent store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write) begin
            mem[addr[0]] <= bus.RD2[7:0];
            if (dm_type != DM_B) begin
                mem[addr[1]] <= bus.RD2[15:8];
            end
            if (dm_type == DM_W) begin
                mem[addr[2]] <= bus.RD2[23:16];
                mem[addr[3]] <= bus.RD2[31:24];
            end
        end
    end

    // Write-back select; the PC+4 code is reserved here and yields 0
    always_comb begin
        unique case (wd_sel)
            WD_ALU:  wd = alu_c;
            WD_MEM:  wd = ld_data;
            default: wd = '0;
        endcase
    end

    assign bus.RegWrite = reg_write;
    assign bus.MemWrite = mem_write;
    assign bus.ALUSrc   = alu_src;
    assign bus.EXTOp    = ext_op;
    assign bus.ALUOp    = alu_op;
    assign bus.DMType   = dm_type;
    assign bus.WDSel    = wd_sel;
    assign bus.aluout   = alu_c;
    assign bus.Zero     = (alu_c == '0);
    assign bus.dout     = ld_data;
    assign bus.WD       = wd;

endmodule

// File: tb/tb_alu_ctrl_dm.sv
// Bench for alu_ctrl_dm: spec vector table, hand-written memory sequences,
// then random instructions against an instruction-level reference model.
module tb_alu_ctrl_dm;

    localparam int unsigned DM = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_dm_if bus();

    alu_ctrl_dm #(.DM_BYTES(DM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_m [DM];

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
        K_LUI, K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW, K_BAD, K_NUM
    } kind_e;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [18:0] ctrl;
        logic [31:0] alu;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] mk(input logic rw, input logic mw, input logic as,
                                       input logic [5:0] ext, input logic [4:0] aop,
                                       input logic [2:0] dmt, input logic [1:0] wds);
        return {rw, mw, as, ext, aop, dmt, wds};
    endfunction

    function automatic logic [31:0] ctrl_act();
        return {13'd0, bus.RegWrite, bus.MemWrite, bus.ALUSrc, bus.EXTOp,
                bus.ALUOp, bus.DMType, bus.WDSel};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_aop(input kind_e k);
        case (k)
            K_ADD, K_ADDI, K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW: return 5'd1;
            K_SUB:          return 5'd2;
            K_SLL, K_SLLI:  return 5'd3;
            K_SLT, K_SLTI:  return 5'd4;
            K_SLTU, K_SLTIU: return 5'd5;
            K_XOR, K_XORI:  return 5'd6;
            K_SRL, K_SRLI:  return 5'd7;
            K_SRA, K_SRAI:  return 5'd8;
            K_OR, K_ORI:    return 5'd9;
            K_AND, K_ANDI:  return 5'd10;
            K_LUI:          return 5'd11;
            default:        return 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_dmt(input kind_e k);
        case (k)
            K_LB, K_SB: return 3'b011;
            K_LH, K_SH: return 3'b001;
            K_LBU:      return 3'b100;
            K_LHU:      return 3'b010;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] ref_ctrl(input kind_e k);
        logic rw = 1'b0, mw = 1'b0, as = 1'b0;
        logic [5:0] ext = '0;
        logic [1:0] wds = '0;
        if (k <= K_AND) rw = 1'b1;
        else if (k <= K_SRAI) begin
            rw = 1'b1; as = 1'b1;
            ext = (k >= K_SLLI) ? 6'b100000 : 6'b010000;
        end else if (k == K_LUI) begin
            rw = 1'b1; as = 1'b1; ext = 6'b000010;
        end else if (k <= K_LHU) begin
            rw = 1'b1; as = 1'b1; ext = 6'b010000; wds = 2'b01;
        end else if (k <= K_SW) begin
            mw = 1'b1; as = 1'b1; ext = 6'b001000;
        end
        return {rw, mw, as, ext, ref_aop(k), ref_dmt(k), wds};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] aop, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh = b[4:0];
        case (aop)
            5'd1:  return a + b;
            5'd2:  return a - b;
            5'd3:  return a << sh;
            5'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd5:  return (a < b) ? 32'd1 : 32'd0;
            5'd6:  return a ^ b;
            5'd7:  return a >> sh;
            5'd8:  return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            5'd9:  return a | b;
            5'd10: return a & b;
            5'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] dmt, input logic [31:0] ad);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = mem_m[(ad + i) % DM];
        case (dmt)
            3'b000: return {b[3], b[2], b[1], b[0]};
            3'b001: return {{16{b[1][7]}}, b[1], b[0]};
            3'b010: return {16'd0, b[1], b[0]};
            3'b011: return {{24{b[0][7]}}, b[0]};
            3'b100: return {24'd0, b[0]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic enc(input kind_e k, output logic [6:0] op, output logic [2:0] f3,
                       output logic [6:0] f7);
        logic [6:0] bad_ops [5];
        bad_ops = '{7'h7F, 7'h63, 7'h6F, 7'h17, 7'h00};
        f7 = 7'($urandom);
        f3 = 3'($urandom);
        if (k <= K_AND)       op = 7'h33;
        else if (k <= K_SRAI) op = 7'h13;
        else if (k == K_LUI)  op = 7'h37;
        else if (k <= K_LHU)  op = 7'h03;
        else if (k <= K_SW)   op = 7'h23;
        else                  op = bad_ops[$urandom_range(0, 4)];
        case (k)
            K_ADD, K_SUB, K_ADDI, K_LB, K_SB:              f3 = 3'b000;
            K_SLL, K_SLLI, K_LH, K_SH:                     f3 = 3'b001;
            K_SLT, K_SLTI, K_LW, K_SW:                     f3 = 3'b010;
            K_SLTU, K_SLTIU:                               f3 = 3'b011;
            K_XOR, K_XORI, K_LBU:                          f3 = 3'b100;
            K_SRL, K_SRA, K_SRLI, K_SRAI, K_LHU:           f3 = 3'b101;
            K_OR, K_ORI:                                   f3 = 3'b110;
            K_AND, K_ANDI:                                 f3 = 3'b111;
            default: ;
        endcase
        if (k <= K_AND) f7 = (k == K_SUB || k == K_SRA) ? 7'h20 : 7'h00;
        if (k == K_SLLI || k == K_SRLI) f7 = 7'h00;
        if (k == K_SRAI) f7 = 7'h20;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
        @(negedge clk);
        rst        = 1'b0;
        bus.Op     = op;
        bus.Funct7 = f7;
        bus.Funct3 = f3;
        bus.RD1    = rd1;
        bus.RD2    = rd2;
        bus.immout = imm;
        #1;
    endtask

    task automatic drive_k(input kind_e k, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm);
        logic [6:0] op, f7;
        logic [2:0] f3;
        enc(k, op, f3, f7);
        drive(op, f7, f3, rd1, rd2, imm);
    endtask

    kind_e       k;
    logic [31:0] r1, r2, im, b, exp_alu, exp_dout;
    logic [18:0] exp_ctrl;
    logic        rst_now;

    initial begin
        bus.Op = '0; bus.Funct7 = '0; bus.Funct3 = '0;
        bus.RD1 = '0; bus.RD2 = '0; bus.immout = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // ---- reset state ----
        drive_k(K_LW, 32'd0, 32'd0, 32'd0);
        chk("reset_dout_0", bus.dout, 32'd0);
        drive_k(K_LW, 32'd124, 32'd0, 32'd0);
        chk("reset_dout_124", bus.dout, 32'd0);

        // ---- vector table ----
        vt[0]  = '{"add", 7'h33, 7'h00, 3'b000, 32'd5, 32'd7, 32'h123,
                   mk(1,0,0,6'b000000,5'd1,3'b000,2'b00), 32'd12};
        vt[1]  = '{"sub", 7'h33, 7'h20, 3'b000, 32'd5, 32'd5, 32'h0,
                   mk(1,0,0,6'b000000,5'd2,3'b000,2'b00), 32'd0};
        vt[2]  = '{"srai", 7'h13, 7'h20, 3'b101, 32'h8000_0000, 32'd0, 32'd4,
                   mk(1,0,1,6'b100000,5'd8,3'b000,2'b00), 32'hF800_0000};
        vt[3]  = '{"srli", 7'h13, 7'h00, 3'b101, 32'h8000_0000, 32'd0, 32'd4,
                   mk(1,0,1,6'b100000,5'd7,3'b000,2'b00), 32'h0800_0000};
        vt[4]  = '{"slt", 7'h33, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0,
                   mk(1,0,0,6'b000000,5'd4,3'b000,2'b00), 32'd1};
        vt[5]  = '{"sltu", 7'h33, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0,
                   mk(1,0,0,6'b000000,5'd5,3'b000,2'b00), 32'd0};
        vt[6]  = '{"lui", 7'h37, 7'h00, 3'b000, 32'd0, 32'd0, 32'h1234_5000,
                   mk(1,0,1,6'b000010,5'd11,3'b000,2'b00), 32'h1234_5000};
        vt[7]  = '{"op7f", 7'h7F, 7'h00, 3'b000, 32'd5, 32'd7, 32'd9,
                   mk(0,0,0,6'b000000,5'd0,3'b000,2'b00), 32'd0};
        vt[8]  = '{"r_bad_f7", 7'h33, 7'h20, 3'b001, 32'd5, 32'd7, 32'd9,
                   mk(0,0,0,6'b000000,5'd0,3'b000,2'b00), 32'd0};
        vt[9]  = '{"ld_bad_f3", 7'h03, 7'h00, 3'b011, 32'd8, 32'd7, 32'd4,
                   mk(0,0,0,6'b000000,5'd0,3'b000,2'b00), 32'd0};
        vt[10] = '{"addi_neg", 7'h13, 7'h7F, 3'b000, 32'd10, 32'd0, 32'hFFFF_FFFF,
                   mk(1,0,1,6'b010000,5'd1,3'b000,2'b00), 32'd9};
        vt[11] = '{"and", 7'h33, 7'h00, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,
                   mk(1,0,0,6'b000000,5'd10,3'b000,2'b00), 32'hF000_F000};

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].op, vt[i].f7, vt[i].f3, vt[i].rd1, vt[i].rd2, vt[i].imm);
            chk({vt[i].name, "_ctrl"}, ctrl_act(), {13'd0, vt[i].ctrl});
            chk({vt[i].name, "_alu"}, bus.aluout, vt[i].alu);
            chk({vt[i].name, "_zero"}, {31'd0, bus.Zero}, {31'd0, vt[i].alu == 32'd0});
        end

        // ---- word store / load, read-before-write in the store cycle ----
        drive_k(K_SW, 32'd0, 32'hDEAD_BEEF, 32'd8);
        chk("sw_old_data", bus.dout, 32'd0);
        @(posedge clk);
        drive_k(K_LW, 32'd0, 32'd0, 32'd8);
        chk("lw8_dout", bus.dout, 32'hDEAD_BEEF);
        chk("lw8_wd", bus.WD, 32'hDEAD_BEEF);
        chk("lw8_wdsel", {30'd0, bus.WDSel}, 32'd1);
        chk("lw8_dmtype", {29'd0, bus.DMType}, 32'd0);

        // ---- sized loads ----
        drive_k(K_LB, 32'd8, 32'd0, 32'd0);
        chk("lb8", bus.WD, 32'hFFFF_FFEF);
        drive_k(K_LBU, 32'd8, 32'd0, 32'd0);
        chk("lbu8", bus.WD, 32'h0000_00EF);
        drive_k(K_LH, 32'd10, 32'd0, 32'd0);
        chk("lh10", bus.WD, 32'hFFFF_DEAD);
        drive_k(K_LHU, 32'd10, 32'd0, 32'd0);
        chk("lhu10", bus.WD, 32'h0000_DEAD);

        // ---- sized store ----
        drive_k(K_SB, 32'd9, 32'h1234_5678, 32'd0);
        @(posedge clk);
        drive_k(K_LW, 32'd8, 32'd0, 32'd0);
        chk("sb9_word8", bus.dout, 32'hDEAD_78EF);

        // ---- store concurrent with reset is dropped, memory cleared ----
        drive_k(K_SW, 32'd8, 32'h5555_AAAA, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        drive_k(K_LW, 32'd8, 32'd0, 32'd0);
        chk("rst_store_dropped", bus.dout, 32'd0);

        // ---- wrap-around word store ----
        drive_k(K_SW, DM - 2, 32'hA1B2_C3D4, 32'd0);
        @(posedge clk);
        drive_k(K_LW, DM - 2, 32'd0, 32'd0);
        chk("wrap_lw", bus.dout, 32'hA1B2_C3D4);
        drive_k(K_LBU, DM - 1, 32'd0, 32'd0);
        chk("wrap_b_top", bus.dout, 32'h0000_00C3);
        drive_k(K_LBU, 32'd0, 32'd0, 32'd0);
        chk("wrap_b0", bus.dout, 32'h0000_00B2);
        drive_k(K_LBU, 32'd1, 32'd0, 32'd0);
        chk("wrap_b1", bus.dout, 32'h0000_00A1);

        // ---- random instructions against the reference model ----
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < DM; i++) mem_m[i] = 8'h00;

        for (int n = 0; n < 500; n++) begin
            k = kind_e'($urandom_range(0, K_NUM - 1));
            if (k >= K_LB && k <= K_SW) begin
                r1 = $urandom_range(0, 300);
                im = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 40));
            end else begin
                r1 = $urandom;
                im = $urandom;
            end
            r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom;
            rst_now = ($urandom_range(0, 49) == 0);

            drive_k(k, r1, r2, im);

            exp_ctrl = ref_ctrl(k);
            b        = (k >= K_ADDI && k != K_BAD) ? im : r2;
            exp_alu  = ref_alu(ref_aop(k), r1, b);
            exp_dout = ref_load(ref_dmt(k), exp_alu);

            chk("rnd_ctrl", ctrl_act(), {13'd0, exp_ctrl});
            chk("rnd_alu", bus.aluout, exp_alu);
            chk("rnd_zero", {31'd0, bus.Zero}, {31'd0, exp_alu == 32'd0});
            chk("rnd_dout", bus.dout, exp_dout);
            chk("rnd_wd", bus.WD, (k >= K_LB && k <= K_LHU) ? exp_dout : exp_alu);

            if (rst_now) rst = 1'b1;
            @(posedge clk);
            if (rst_now) begin
                for (int i = 0; i < DM; i++) mem_m[i] = 8'h00;
            end else if (k >= K_SB && k <= K_SW) begin
                int nb;
                nb = (k == K_SB) ? 1 : (k == K_SH) ? 2 : 4;
                for (int i = 0; i < nb; i++) mem_m[(exp_alu + i) % DM] = r2[8*i +: 8];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
